// File: rtl/ysyx_24110015_bpu_pkg.sv
// Shared definitions for the ysyx_24110015 branch predictor.
// - ctr_e   : 2-bit saturating direction counter encodings
// - entry_t : one BTB entry (valid, tag, target, jal flag, counter)
// Tags are stored zero-extended to TAG_MAX_W. This keeps one struct type
// usable for every legal ENTRIES value (4..64).
package ysyx_24110015_bpu_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  // Widest tag is pc[31:4], which occurs at the smallest table (ENTRIES=4).
  localparam int unsigned TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 jal;
    ctr_e                 ctr;
  } entry_t;

endpackage

// File: rtl/ysyx_24110015_sat_counter.sv
// 2-bit saturating up/down counter step (combinational).
// Ports:
//   cnt      in  current counter state
//   taken    in  1 = increment toward STRONG_T, 0 = decrement toward STRONG_NT
//   cnt_next out next counter state, saturating at both ends
module ysyx_24110015_sat_counter
  import ysyx_24110015_bpu_pkg::*;
(
  input  ctr_e cnt,
  input  logic taken,
  output ctr_e cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != STRONG_T) cnt_next = ctr_e'(cnt + 2'd1);
    end else begin
      if (cnt != STRONG_NT) cnt_next = ctr_e'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/ysyx_24110015_bpu.sv
// Direct-mapped BTB with per-entry 2-bit direction counters.
// Lookups are combinational. Updates from EXU are written on the next posedge.
// A lookup of an index that is being updated in the same cycle sees the old entry.
// Ports:
//   clk, rst (sync, active-low)
//   lookup_valid_i, lookup_pc_i        : IFU fetch request
//   pc_predict_o, pred_taken_o         : predicted next PC / redirect flag
//   update_valid_i, update_branch_i, update_jal_i,
//   update_pc_i, update_target_i       : resolved control flow (1-cycle pulse)
//   mispredict_i                       : EXU control-hazard pulse
//   perf_lookup_o, perf_hit_o, perf_mispred_o : counters
// The counter ports exist only when YSYX_24110015_BPU_PERF_EN is defined.
module ysyx_24110015_bpu
  import ysyx_24110015_bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter logic [31:0] RST_PC  = 32'h20000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic [31:0] pc_predict_o,
  output logic        pred_taken_o,
  input  logic        update_valid_i,
  input  logic        update_branch_i,
  input  logic        update_jal_i,
  input  logic [31:0] update_pc_i,
  input  logic [31:0] update_target_i,
  input  logic        mispredict_i
`ifdef YSYX_24110015_BPU_PERF_EN
  ,
  output logic [31:0] perf_lookup_o,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_mispred_o
`endif
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  entry_t tbl [ENTRIES];

  logic [IDX-1:0]       lk_idx, up_idx;
  logic [TAG_MAX_W-1:0] lk_tag, up_tag;
  entry_t               lk_e;
  logic                 lk_hit, up_hit, br_taken;
  ctr_e                 ctr_next;

  assign lk_idx = lookup_pc_i[IDX+1:2];
  assign lk_tag = TAG_MAX_W'(lookup_pc_i[31:IDX+2]);
  assign up_idx = update_pc_i[IDX+1:2];
  assign up_tag = TAG_MAX_W'(update_pc_i[31:IDX+2]);

  assign lk_e     = tbl[lk_idx];
  assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
  assign up_hit   = tbl[up_idx].valid && (tbl[up_idx].tag == up_tag);
  assign br_taken = (update_target_i != update_pc_i + 32'd4);

  always_comb begin
    pc_predict_o = lookup_pc_i + 32'd4;
    pred_taken_o = 1'b0;
    if (!rst) begin
      pc_predict_o = RST_PC;
    end else if (lk_hit && (lk_e.jal || lk_e.ctr[1])) begin
      pc_predict_o = lk_e.target;
      pred_taken_o = 1'b1;
    end
  end

  ysyx_24110015_sat_counter u_sat_counter (
    .cnt      (tbl[up_idx].ctr),
    .taken    (br_taken),
    .cnt_next (ctr_next)
  );

  // Targets and tags are left unreset; valid=0 already masks them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl[IDX'(i)].valid <= 1'b0;
        tbl[IDX'(i)].jal   <= 1'b0;
        tbl[IDX'(i)].ctr   <= STRONG_NT;
      end
    end else if (update_valid_i) begin
      if (update_jal_i) begin
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: update_target_i,
                         jal: 1'b1, ctr: STRONG_T};
      end else if (update_branch_i) begin
        if (up_hit) begin
          tbl[up_idx].ctr <= ctr_next;
          if (br_taken) tbl[up_idx].target <= update_target_i;
        end else if (br_taken) begin
          tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: update_target_i,
                           jal: 1'b0, ctr: WEAK_T};
        end
      end
    end
  end

`ifdef YSYX_24110015_BPU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lookup_o  <= '0;
      perf_hit_o     <= '0;
      perf_mispred_o <= '0;
    end else begin
      if (lookup_valid_i)           perf_lookup_o  <= perf_lookup_o + 32'd1;
      if (lookup_valid_i && lk_hit) perf_hit_o     <= perf_hit_o + 32'd1;
      if (mispredict_i)             perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`else
  logic [1:0] unused_perf_inputs;
  assign unused_perf_inputs = {lookup_valid_i, mispredict_i};
`endif

endmodule

// File: doc/ysyx_24110015_bpu.md
YSYX_24110015_BPU -- requirements
Module: ysyx_24110015_bpu

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, BTB entry count (power of 2, 4..64).
REQ-002 SHALL have parameter RST_PC, default 32'h20000000, pc_predict_o value while in reset.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port lookup_valid_i  in  1  IFU fetch request valid this cycle.
REQ-006 SHALL have port lookup_pc_i  in  32  PC being fetched.
REQ-007 SHALL have port pc_predict_o  out  32  predicted next PC (combinational from lookup_pc_i).
REQ-008 SHALL have port pred_taken_o  out  1  prediction is redirect (not pc+4).
REQ-009 SHALL have ports update_valid_i in 1, update_branch_i in 1, update_jal_i in 1, update_pc_i in 32, update_target_i in 32  resolved control-flow from EXU (one-cycle pulse).
REQ-010 SHALL have port mispredict_i  in  1  EXU control_hazard pulse.
REQ-011 SHALL have ports perf_lookup_o, perf_hit_o, perf_mispred_o  out  32 each  counters (present only per REQ-026).

Function
REQ-012 SHALL index the table with pc[IDX+1:2], IDX=log2(ENTRIES); tag = pc[31:IDX+2].
REQ-013 SHALL hold per entry: valid, tag, target[31:0], jal flag, 2-bit saturating counter.
REQ-014 SHALL signal hit when entry valid and tag matches; lookup is zero-latency combinational.
REQ-015 SHALL output pc_predict_o = target and pred_taken_o=1 when hit and (jal flag or counter[1]); otherwise lookup_pc_i+4, pred_taken_o=0.
REQ-016 SHALL compute update taken = (update_target_i != update_pc_i+4) for branches; jal always taken.
REQ-017 On update_valid_i with update_jal_i: SHALL write valid=1, tag, target, jal=1, counter=2'b11, overwriting any alias.
REQ-018 On branch update, entry hit: SHALL increment (taken) or decrement (not taken) counter, saturating at 2'b11/2'b00; SHALL rewrite target only when taken.
REQ-019 On branch update, entry miss: taken SHALL allocate with counter=2'b10, jal=0; not-taken SHALL leave table unchanged.
REQ-020 SHALL ignore update_valid_i when neither update_branch_i nor update_jal_i set.
REQ-021 Update and lookup of same index in same cycle: lookup SHALL see pre-update contents (no bypass); update takes effect next cycle.
REQ-022 Replacement SHALL be direct-mapped; tag mismatch on allocate overwrites the whole entry.

Reset
REQ-023 While rst=0 at posedge: all valid bits, counters, jal flags SHALL clear to 0; targets/tags need not reset.
REQ-024 While rst=0: pc_predict_o SHALL equal RST_PC, pred_taken_o=0; updates SHALL be ignored.
REQ-025 Reset asserted mid-operation SHALL discard any concurrent update; first post-reset lookup misses.

Configuration
REQ-026 With YSYX_24110015_BPU_PERF_EN defined: three 32-bit counters SHALL exist, reset to 0, increment on lookup_valid_i, lookup_valid_i&hit, mispredict_i respectively, wrapping 0xFFFFFFFF->0.
REQ-027 Without YSYX_24110015_BPU_PERF_EN: perf ports and counters SHALL be absent; prediction behaviour identical.

Structure
REQ-028 Shared package SHALL hold counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and entry struct typedef.
REQ-029 One sub-module ysyx_24110015_sat_counter (2-bit saturating inc/dec) SHALL be natural; table stays inline.

Verification
REQ-030 Reset, lookup_pc_i=0x80000000 -> pc_predict_o=0x80000004, pred_taken_o=0; during reset pc_predict_o=0x20000000.
REQ-031 jal update pc=0x80000010 target=0x80000100; next cycle lookup 0x80000010 -> 0x80000100, taken=1.
REQ-032 Branch pc=0x80000020 taken to 0x80000000 once -> counter 10, predict taken; two not-taken updates -> counter 00, predict 0x80000024.
REQ-033 Alias: ENTRIES=16, jal at 0x80000010 then jal at 0x80000050 -> lookup 0x80000010 misses (0x80000014).
REQ-034 Same-cycle update+lookup of 0x80000030 -> lookup returns old prediction, next cycle new.
REQ-035 With YSYX_24110015_BPU_PERF_EN: 5 lookups (2 hits), 1 mispredict pulse -> counters 5/2/1; preload 0xFFFFFFFF wraps to 0.
